// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Counters are carried in a fixed 4-bit container (the widest supported
// counter); the active width is passed alongside so one helper serves
// every CTR_BITS setting.
package branch_predictor_gshare_pkg;

  localparam int BPU_CTR_MAX_BITS = 4;

  typedef logic [BPU_CTR_MAX_BITS-1:0] bpu_ctr_t;

  // Weakly not-taken value for a counter of the given width.
  function automatic bpu_ctr_t bpu_ctr_reset(input int unsigned width);
    return bpu_ctr_t'((32'd1 << (width - 32'd1)) - 32'd1);
  endfunction

  // Saturating up/down step of a counter of the given width.
  function automatic bpu_ctr_t bpu_sat_update(input bpu_ctr_t ctr,
                                              input logic taken,
                                              input int unsigned width);
    bpu_ctr_t max_v;
    max_v = bpu_ctr_t'((32'd1 << width) - 32'd1);
    if (taken) begin
      if (ctr >= max_v) return max_v;
      else              return ctr + 4'd1;
    end else begin
      if (ctr == 4'd0) return 4'd0;
      else             return ctr - 4'd1;
    end
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// IF/EX facing bus of the branch predictor. The master modport is the
// pipeline side (drives fetch PC and resolved branches); the slave modport
// is the predictor.
interface branch_predictor_gshare_if #(
  parameter int IDX_W = 4
) ();
  logic [31:0]      if_pc_ip;
  logic             pred_taken_op;
  logic [IDX_W-1:0] pred_index_op;
  logic             ex_valid_ip;
  logic [IDX_W-1:0] ex_index_ip;
  logic             ex_taken_ip;
  logic             ex_pred_ip;
  logic             mispredict_op;

  modport master (
    output if_pc_ip, ex_valid_ip, ex_index_ip, ex_taken_ip, ex_pred_ip,
    input  pred_taken_op, pred_index_op, mispredict_op
  );

  modport slave (
    input  if_pc_ip, ex_valid_ip, ex_index_ip, ex_taken_ip, ex_pred_ip,
    output pred_taken_op, pred_index_op, mispredict_op
  );
endinterface

// File: rtl/branch_predictor_gshare_pht.sv
// Pattern history table: array of saturating counters with one
// combinational read port and one synchronous read-modify-write port.
// Reads see the pre-update value when both ports hit the same entry.
module bpu_pht
  import branch_predictor_gshare_pkg::*;
#(
  parameter int PHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  localparam int IDX_W      = $clog2(PHT_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [CTR_BITS-1:0] rd_ctr_o,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic                wr_taken_i
);

  localparam bpu_ctr_t BPU_CTR_RESET = bpu_ctr_reset(CTR_BITS);

  logic [CTR_BITS-1:0] ctr_q [PHT_ENTRIES];
  logic [CTR_BITS-1:0] ctr_d;
  bpu_ctr_t            cur_s;

  assign rd_ctr_o = ctr_q[rd_idx_i];

  // Next value of the entry being written: widen, step, narrow back.
  always_comb begin
    cur_s                 = '0;
    cur_s[CTR_BITS-1:0]   = ctr_q[wr_idx_i];
    ctr_d                 = CTR_BITS'(bpu_sat_update(cur_s, wr_taken_i, CTR_BITS));
  end

  // Counter storage: async clear to weakly not-taken, single-entry update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        ctr_q[i] <= BPU_CTR_RESET[CTR_BITS-1:0];
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare / bimodal branch predictor top: index hashing, non-speculative
// global history, mispredict detection and optional perf counters.
// Optional feature macro: BPU_PERF_EN (adds perf_branches_op/perf_mispred_op).
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int PHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 4,
  parameter int GSHARE      = 1,
  localparam int IDX_W      = $clog2(PHT_ENTRIES)
) (
  input logic clk,
  input logic rst,
  branch_predictor_gshare_if.slave bus
`ifdef BPU_PERF_EN
  ,
  output logic [31:0] perf_branches_op,
  output logic [31:0] perf_mispred_op
`endif
);

  if ((PHT_ENTRIES < 2) || ((PHT_ENTRIES & (PHT_ENTRIES - 1)) != 0)) begin : g_bad_pht
    $error("PHT_ENTRIES must be a power of two >= 2");
  end
  if ((GHR_BITS < 1) || (GHR_BITS > IDX_W)) begin : g_bad_ghr
    $error("GHR_BITS must be in 1..IDX_W");
  end
  if ((CTR_BITS < 1) || (CTR_BITS > BPU_CTR_MAX_BITS)) begin : g_bad_ctr
    $error("CTR_BITS must be in 1..4");
  end

  logic [IDX_W-1:0]    base_idx_s;
  logic [IDX_W-1:0]    ghr_ext_s;
  logic [IDX_W-1:0]    pred_idx_s;
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  logic [GHR_BITS:0]   ghr_shift_s;
  logic [CTR_BITS-1:0] rd_ctr_s;
  logic                unused_pc_s;

  assign unused_pc_s = ^{bus.if_pc_ip[31:IDX_W+2], bus.if_pc_ip[1:0]};

  // Prediction index: word-aligned PC bits, optionally hashed with history.
  always_comb begin
    base_idx_s               = bus.if_pc_ip[IDX_W+1:2];
    ghr_ext_s                = '0;
    ghr_ext_s[GHR_BITS-1:0]  = ghr_q;
    if (GSHARE != 0) begin
      pred_idx_s = base_idx_s ^ ghr_ext_s;
    end else begin
      pred_idx_s = base_idx_s;
    end
  end

  bpu_pht #(
    .PHT_ENTRIES (PHT_ENTRIES),
    .CTR_BITS    (CTR_BITS)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pred_idx_s),
    .rd_ctr_o   (rd_ctr_s),
    .wr_en_i    (bus.ex_valid_ip),
    .wr_idx_i   (bus.ex_index_ip),
    .wr_taken_i (bus.ex_taken_ip)
  );

  assign bus.pred_index_op = pred_idx_s;
  assign bus.pred_taken_op = rd_ctr_s[CTR_BITS-1];
  assign bus.mispredict_op = bus.ex_valid_ip & (bus.ex_taken_ip != bus.ex_pred_ip);

  // History shift with newest outcome in the LSB; also covers GHR_BITS=1.
  always_comb begin
    ghr_shift_s = {ghr_q, bus.ex_taken_ip};
    ghr_d       = ghr_shift_s[GHR_BITS-1:0];
  end

  // Global history register, advanced only by resolved branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (bus.ex_valid_ip) begin
      ghr_q <= ghr_d;
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mp_q;

  // Saturating counts of resolved branches and of mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= 32'd0;
      perf_mp_q <= 32'd0;
    end else begin
      if (bus.ex_valid_ip && (perf_br_q != 32'hFFFF_FFFF)) begin
        perf_br_q <= perf_br_q + 32'd1;
      end
      if (bus.mispredict_op && (perf_mp_q != 32'hFFFF_FFFF)) begin
        perf_mp_q <= perf_mp_q + 32'd1;
      end
    end
  end

  assign perf_branches_op = perf_br_q;
  assign perf_mispred_op  = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench: a bimodal and a gshare instance driven with the same
// stimulus, checked against an independent reference model through a
// scoreboard queue. Perf counter checks compile in with BPU_PERF_EN.
module tb_branch_predictor_gshare;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_gshare_if #(.IDX_W(4)) bus_b ();
  branch_predictor_gshare_if #(.IDX_W(4)) bus_g ();

`ifdef BPU_PERF_EN
  logic [31:0] perf_br_b, perf_mp_b, perf_br_g, perf_mp_g;
`endif

  branch_predictor_gshare #(.PHT_ENTRIES(16), .CTR_BITS(2), .GHR_BITS(4), .GSHARE(0)) u_bim (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
`ifdef BPU_PERF_EN
    , .perf_branches_op (perf_br_b), .perf_mispred_op (perf_mp_b)
`endif
  );

  branch_predictor_gshare #(.PHT_ENTRIES(16), .CTR_BITS(2), .GHR_BITS(4), .GSHARE(1)) u_gsh (
    .clk (clk),
    .rst (rst),
    .bus (bus_g)
`ifdef BPU_PERF_EN
    , .perf_branches_op (perf_br_g), .perf_mispred_op (perf_mp_g)
`endif
  );

  typedef struct {
    logic        pred_b;
    logic [3:0]  idx_b;
    logic        pred_g;
    logic [3:0]  idx_g;
    logic        misp;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t sb_q[$];

  logic [1:0]  m_pht_b [16];
  logic [1:0]  m_pht_g [16];
  logic [3:0]  m_ghr;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pht_b[i] = 2'd1;
      m_pht_g[i] = 2'd1;
    end
    m_ghr = 4'd0;
    m_br  = 32'd0;
    m_mp  = 32'd0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic v, input logic [3:0] idx,
                       input logic t, input logic p);
    bus_b.if_pc_ip = pc;  bus_g.if_pc_ip = pc;
    bus_b.ex_valid_ip = v; bus_g.ex_valid_ip = v;
    bus_b.ex_index_ip = idx; bus_g.ex_index_ip = idx;
    bus_b.ex_taken_ip = t; bus_g.ex_taken_ip = t;
    bus_b.ex_pred_ip = p;  bus_g.ex_pred_ip = p;
  endtask

  // One cycle: drive, push model expectation, compare at negedge, advance.
  task automatic step(input logic [31:0] pc, input logic v, input logic [3:0] idx,
                      input logic t, input logic p);
    exp_t e;
    exp_t o;
    logic [3:0] base;
    drive(pc, v, idx, t, p);
    base     = pc[5:2];
    e.idx_b  = base;
    e.idx_g  = base ^ m_ghr;
    e.pred_b = m_pht_b[base][1];
    e.pred_g = m_pht_g[e.idx_g][1];
    e.misp   = v & (t != p);
    e.br     = m_br;
    e.mp     = m_mp;
    sb_q.push_back(e);
    if (v) begin
      m_pht_b[idx] = sat2(m_pht_b[idx], t);
      m_pht_g[idx] = sat2(m_pht_g[idx], t);
      m_ghr        = {m_ghr[2:0], t};
      m_br         = m_br + 32'd1;
      if (t != p) m_mp = m_mp + 32'd1;
    end
    @(negedge clk);
    o = sb_q.pop_front();
    check_val("pred_b", {31'd0, bus_b.pred_taken_op}, {31'd0, o.pred_b});
    check_val("idx_b",  {28'd0, bus_b.pred_index_op}, {28'd0, o.idx_b});
    check_val("pred_g", {31'd0, bus_g.pred_taken_op}, {31'd0, o.pred_g});
    check_val("idx_g",  {28'd0, bus_g.pred_index_op}, {28'd0, o.idx_g});
    check_val("misp",   {31'd0, bus_b.mispredict_op}, {31'd0, o.misp});
`ifdef BPU_PERF_EN
    check_val("perf_br", perf_br_g, o.br);
    check_val("perf_mp", perf_mp_g, o.mp);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0000_0004, 1'b0, 4'd0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_val("rst_pred_b", {31'd0, bus_b.pred_taken_op}, 32'd0);
    check_val("rst_pred_g", {31'd0, bus_g.pred_taken_op}, 32'd0);
    check_val("rst_misp",   {31'd0, bus_g.mispredict_op}, 32'd0);
    check_val("rst_idx_g",  {28'd0, bus_g.pred_index_op}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Sweep every entry: all weakly not-taken, history zero.
    for (int i = 0; i < 16; i++) step(32'(i * 4), 1'b0, 4'd0, 1'b0, 1'b0);

    // Same-cycle hit on entry 3 plus mispredict, then the visible update.
    step(32'h0C, 1'b1, 4'd3, 1'b1, 1'b0);
    step(32'h0C, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("idx3_taken", {31'd0, bus_b.pred_taken_op}, 32'd1);
    step(32'h0C, 1'b1, 4'd3, 1'b0, 1'b1);
    step(32'h0C, 1'b0, 4'd0, 1'b0, 1'b0);

    // Saturation on entry 5.
    for (int i = 0; i < 5; i++) step(32'h14, 1'b1, 4'd5, 1'b1, 1'b1);
    step(32'h14, 1'b1, 4'd5, 1'b0, 1'b1);
    step(32'h14, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("sat_hi", {31'd0, bus_b.pred_taken_op}, 32'd1);
    for (int i = 0; i < 4; i++) step(32'h14, 1'b1, 4'd5, 1'b0, 1'b0);
    step(32'h14, 1'b1, 4'd5, 1'b1, 1'b0);
    step(32'h14, 1'b0, 4'd0, 1'b0, 1'b0);

    // History 0110 after not-taken, taken, taken, not-taken.
    step(32'h0, 1'b1, 4'd9, 1'b0, 1'b0);
    step(32'h0, 1'b1, 4'd9, 1'b1, 1'b0);
    step(32'h0, 1'b1, 4'd9, 1'b1, 1'b0);
    step(32'h0, 1'b1, 4'd9, 1'b0, 1'b0);
    drive(32'h04, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check_val("ghr_idx", {28'd0, bus_g.pred_index_op}, 32'd7);
    step(32'h04, 1'b0, 4'd0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step(32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with an update pending.
    for (int i = 0; i < 4; i++) step(32'h0C, 1'b1, 4'd3, 1'b1, 1'b0);
    drive(32'h0C, 1'b1, 4'd3, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_pred_b", {31'd0, bus_b.pred_taken_op}, 32'd0);
    check_val("arst_pred_g", {31'd0, bus_g.pred_taken_op}, 32'd0);
    check_val("arst_idx_g",  {28'd0, bus_g.pred_index_op}, 32'd3);
`ifdef BPU_PERF_EN
    check_val("arst_perf_br", perf_br_g, 32'd0);
    check_val("arst_perf_mp", perf_mp_g, 32'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Ten branches, three mispredicts; first update right after release.
    for (int i = 0; i < 10; i++) begin
      step(32'h0C, 1'b1, 4'd3, 1'b1, (i < 3) ? 1'b0 : 1'b1);
    end
`ifdef BPU_PERF_EN
    check_val("perf_br_10", perf_br_b, 32'd10);
    check_val("perf_mp_3",  perf_mp_b, 32'd3);
`endif
    step(32'h0C, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("post_rst_taken", {31'd0, bus_b.pred_taken_op}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
